// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0, MSB first), oversampled on HCLK, serving READ/RDID/RDSR/WREN/WRDI.
// Optional PAGE PROGRAM (0x02) enabled by defining SPI_FLASH_PROGRAM_EN.
module spi_flash_responder #(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'h20BA18
) (
  input  logic              HCLK,
  input  logic              HRST,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_miso_oe,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [7:0]        i_load_data,
  output logic              o_busy
);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
`ifdef SPI_FLASH_PROGRAM_EN
  localparam logic [7:0] OP_PP   = 8'h02;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DOUT, S_DIN, S_IGNORE} state_t;

  state_t            state, state_nx;
  logic [1:0]        sck_s, cs_s, mosi_s;
  logic              sck_d, cs_d, armed;
  logic              cs_lvl, cs_fall, cs_rise, sck_rise, sck_fall, mosi;
  logic [2:0]        bit_cnt;
  logic [3:0]        bit_total;
  logic [1:0]        byte_cnt;
  logic [6:0]        shift_in;
  logic [7:0]        byte_in, opcode, shift_out, next_byte, mem_q;
  logic [ADDR_W-1:0] addr_sr, ptr;
  logic              wel, byte_done, spi_we;
  logic [7:0]        mem [0:2**ADDR_W-1];

  // Synchronizers reset to 0 so a CS already low when reset lifts never looks like a fall.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      sck_s  <= 2'b00;
      cs_s   <= 2'b00;
      mosi_s <= 2'b00;
      sck_d  <= 1'b0;
      cs_d   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], i_spi_clk};
      cs_s   <= {cs_s[0], i_spi_cs};
      mosi_s <= {mosi_s[0], i_spi_mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_s[1];
      if (cs_s[1]) armed <= 1'b1;
    end
  end

  assign cs_lvl    = cs_s[1];
  assign cs_fall   = cs_d & ~cs_lvl;
  assign cs_rise   = ~cs_d & cs_lvl;
  assign sck_rise  = sck_s[1] & ~sck_d & ~cs_lvl;
  assign sck_fall  = ~sck_s[1] & sck_d & ~cs_lvl;
  assign mosi      = mosi_s[1];
  assign byte_in   = {shift_in, mosi};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != S_IDLE);
  assign o_busy    = armed & ~cs_lvl;

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = S_IDLE;
    end else if (cs_fall) begin
      state_nx = S_CMD;
    end else if (byte_done) begin
      case (state)
        S_CMD: begin
          case (byte_in)
            OP_READ: state_nx = S_ADDR;
`ifdef SPI_FLASH_PROGRAM_EN
            OP_PP:   state_nx = S_ADDR;
`endif
            OP_RDID, OP_RDSR: state_nx = S_DOUT;
            default: state_nx = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          if (byte_cnt == 2'd2) begin
`ifdef SPI_FLASH_PROGRAM_EN
            state_nx = (opcode == OP_PP) ? S_DIN : S_DOUT;
`else
            state_nx = S_DOUT;
`endif
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    o_miso_oe  = (state == S_DOUT) && !cs_lvl;
    o_spi_miso = o_miso_oe & shift_out[7];
  end

  always_comb begin
    next_byte = 8'h00;
    case (opcode)
      OP_READ: next_byte = mem_q;
      OP_RDID: begin
        case (byte_cnt)
          2'd0:    next_byte = JEDEC_ID[23:16];
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'h00;
        endcase
      end
      OP_RDSR: next_byte = {6'b0, wel, 1'b0};
      default: next_byte = 8'h00;
    endcase
  end

`ifdef SPI_FLASH_PROGRAM_EN
  assign spi_we = byte_done && (state == S_DIN) && wel;
`else
  assign spi_we = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      bit_cnt   <= 3'd0;
      bit_total <= 4'd0;
      byte_cnt  <= 2'd0;
      shift_in  <= 7'd0;
      opcode    <= 8'h00;
      addr_sr   <= '0;
      ptr       <= '0;
      shift_out <= 8'h00;
      wel       <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt   <= 3'd0;
      bit_total <= 4'd0;
      byte_cnt  <= 2'd0;
      opcode    <= 8'h00;
      shift_out <= 8'h00;
    end else if (cs_rise) begin
      shift_out <= 8'h00;
      // Write-enable changes only for a clean 8-clock command.
      if (bit_total == 4'd8 && opcode == OP_WREN) wel <= 1'b1;
      if (bit_total == 4'd8 && opcode == OP_WRDI) wel <= 1'b0;
`ifdef SPI_FLASH_PROGRAM_EN
      if (opcode == OP_PP) wel <= 1'b0;
`endif
    end else begin
      if (sck_rise && state != S_IDLE) begin
        shift_in <= byte_in[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_total != 4'hF) bit_total <= bit_total + 4'd1;
        if (state == S_ADDR) addr_sr <= {addr_sr[ADDR_W-2:0], mosi};
        if (bit_cnt == 3'd7) begin
          case (state)
            S_CMD: begin
              opcode   <= byte_in;
              byte_cnt <= 2'd0;
            end
            S_ADDR: begin
              if (byte_cnt == 2'd2) begin
                ptr      <= {addr_sr[ADDR_W-2:0], mosi};
                byte_cnt <= 2'd0;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
            S_DOUT: begin
              // Prefetch the following byte well ahead of the fall that loads it.
              if (opcode == OP_READ) ptr <= ptr + 1'b1;
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            end
`ifdef SPI_FLASH_PROGRAM_EN
            S_DIN: ptr <= {ptr[ADDR_W-1:8], ptr[7:0] + 8'd1};
`endif
            default: ;
          endcase
        end
      end
      if (sck_fall && state == S_DOUT)
        shift_out <= (bit_cnt == 3'd0) ? next_byte : {shift_out[6:0], 1'b0};
    end
  end

  // Backdoor load is written last so it wins a same-address collision.
  always_ff @(posedge HCLK) begin
    if (spi_we)    mem[ptr] <= byte_in;
    if (i_load_en) mem[i_load_addr] <= i_load_data;
    mem_q <= mem[ptr];
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder against a transaction-level flash model.
module tb_spi_flash_responder;
  localparam int HALF = 50;
  localparam logic [23:0] ID = 24'h20BA18;

  logic        HCLK = 1'b0;
  logic        HRST = 1'b1;
  logic        sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = 16'h0;
  logic [7:0]  load_data = 8'h0;
  logic        miso, oe, busy;

  always #5 HCLK = ~HCLK;

  spi_flash_responder dut (
    .HCLK(HCLK), .HRST(HRST),
    .i_spi_clk(sck), .i_spi_cs(cs), .i_spi_mosi(mosi),
    .o_spi_miso(miso), .o_miso_oe(oe),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .o_busy(busy)
  );

  int         n_vec = 0, n_err = 0;
  logic [7:0] model [0:65535];
  logic       wel_m = 1'b0;
  logic [7:0] txb[$];
  logic [7:0] rxb [16];
  logic [7:0] oem [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    @(negedge HCLK);
    load_en = 1'b1; load_addr = a; load_data = d;
    model[a] = d;
    @(negedge HCLK);
    load_en = 1'b0;
  endtask

  task automatic sck_bit(input logic m, output logic mi, output logic o);
    mosi = m;
    #HALF;
    sck = 1'b1;
    mi = miso;
    o = oe;
    #HALF;
    sck = 1'b0;
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0]  op;
    logic [15:0] a;
    op = txb[0];
    a  = {txb[2], txb[3]};
    if (k == 0) return 8'h00;
    case (op)
      8'h03:   return (k < 4) ? 8'h00 : model[a + 16'(k - 4)];
      8'h9F:   return (k == 1) ? ID[23:16] : (k == 2) ? ID[15:8] : (k == 3) ? ID[7:0] : 8'h00;
      8'h05:   return {6'b0, wel_m, 1'b0};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_oe(input int k);
    logic [7:0] op;
    op = txb[0];
    if (k == 0) return 1'b0;
    return (op == 8'h9F) || (op == 8'h05) || (op == 8'h03 && k >= 4);
  endfunction

  task automatic model_update(input int nbits);
    logic [7:0]  op;
    logic [15:0] a;
    op = txb[0];
    a  = {txb[2], txb[3]};
    if (nbits == 8 && op == 8'h06) wel_m = 1'b1;
    if (nbits == 8 && op == 8'h04) wel_m = 1'b0;
`ifdef SPI_FLASH_PROGRAM_EN
    if (op == 8'h02 && nbits >= 8) begin
      if (wel_m)
        for (int k = 4; k < nbits / 8; k++)
          model[{a[15:8], a[7:0] + 8'(k - 4)}] = txb[k];
      wel_m = 1'b0;
    end
`else
    if (a == 16'hFFFF && nbits < 0) wel_m = 1'b0;
`endif
  endtask

  task automatic do_txn(input int nbits, input string tag);
    logic       mi, o;
    logic [7:0] cur;
    int         nb;
    nb = (nbits + 7) / 8;
    while (txb.size() < nb) txb.push_back(8'h00);
    for (int k = 0; k < 16; k++) begin rxb[k] = 8'h00; oem[k] = 8'h00; end
    @(negedge HCLK);
    cs = 1'b0;
    #HALF;
    check({tag, "_busy"}, busy, 1);
    for (int i = 0; i < nbits; i++) begin
      cur = txb[i / 8];
      sck_bit(cur[7 - (i % 8)], mi, o);
      rxb[i / 8] = {rxb[i / 8][6:0], mi};
      oem[i / 8] = {oem[i / 8][6:0], o};
    end
    #HALF;
    cs = 1'b1;
    #(4 * HALF);
    check({tag, "_oe_idle"}, oe, 0);
    check({tag, "_busy_idle"}, busy, 0);
    for (int k = 0; k < nbits / 8; k++) begin
      check($sformatf("%s_b%0d", tag, k), rxb[k], exp_byte(k));
      check($sformatf("%s_oe%0d", tag, k), oem[k], exp_oe(k) ? 8'hFF : 8'h00);
    end
    model_update(nbits);
    txb.delete();
  endtask

  initial begin
    logic        mi, o;
    logic [15:0] st;
    logic [7:0]  op;
    int          kind, len;

    #1;
    check("rst_miso", miso, 0);
    check("rst_oe", oe, 0);
    check("rst_busy", busy, 0);
    #19;
    HRST = 1'b0;
    #100;

    for (int i = 0; i < 512; i++) load(16'hFF00 + 16'(i), 8'($urandom));
    load(16'h0100, 8'h31); load(16'h01FE, 8'h32); load(16'h01FF, 8'h33);

    // basic read
    load(16'h0000, 8'h11); load(16'h0001, 8'h22); load(16'h0002, 8'h33); load(16'h0003, 8'h44);
    txb = '{8'h03, 8'h00, 8'h00, 8'h00};
    do_txn(64, "read0");
    // address wrap
    load(16'hFFFF, 8'hA5); load(16'h0000, 8'h5A);
    txb = '{8'h03, 8'h00, 8'hFF, 8'hFF};
    do_txn(48, "wrap");
    check("wrap_lit0", rxb[4], 8'hA5);
    check("wrap_lit1", rxb[5], 8'h5A);
    // ID and status register
    txb = '{8'h9F}; do_txn(40, "rdid");
    check("rdid_lit", {rxb[1], rxb[2], rxb[3], rxb[4]}, 32'h20BA1800);
    txb = '{8'h05}; do_txn(16, "rdsr0");
    txb = '{8'h06}; do_txn(8, "wren");
    txb = '{8'h05}; do_txn(16, "rdsr1");
    check("rdsr_wel_lit", rxb[1], 8'h02);
    txb = '{8'h04}; do_txn(8, "wrdi");
    txb = '{8'h05}; do_txn(16, "rdsr2");
    check("rdsr_clr_lit", rxb[1], 8'h00);
    // aborted read then RDID
    txb = '{8'h03, 8'h00, 8'h00}; do_txn(13, "abort");
    txb = '{8'h9F}; do_txn(32, "rdid2");
    // page program (or ignored 0x02)
    txb = '{8'h06}; do_txn(8, "wren2");
    txb = '{8'h02, 8'h00, 8'h01, 8'hFE, 8'hAA, 8'hBB, 8'hCC}; do_txn(56, "pp");
    txb = '{8'h05}; do_txn(16, "rdsr3");
    txb = '{8'h03, 8'h00, 8'h01, 8'hFE}; do_txn(48, "pprd");
    txb = '{8'h03, 8'h00, 8'h01, 8'h00}; do_txn(40, "pprd2");
    txb = '{8'h04}; do_txn(8, "wrdi2");
    txb = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h77}; do_txn(40, "pp_nowel");
    txb = '{8'h03, 8'h00, 8'h01, 8'h00}; do_txn(40, "pprd3");

    // reset in the middle of a data byte
    load(16'h0040, 8'hFF);
    @(negedge HCLK);
    cs = 1'b0;
    #HALF;
    txb = '{8'h03, 8'h00, 8'h00, 8'h40};
    for (int i = 0; i < 35; i++) begin
      op = txb[i / 8];
      sck_bit((i < 32) ? op[7 - (i % 8)] : 1'b0, mi, o);
    end
    #HALF;
    check("prerst_oe", oe, 1);
    check("prerst_miso", miso, 1);
    HRST = 1'b1;
    #1;
    check("hrst_miso", miso, 0);
    check("hrst_oe", oe, 0);
    check("hrst_busy", busy, 0);
    #9;
    #10;
    HRST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sck_bit(1'b1, mi, o);
      check($sformatf("postrst_oe%0d", i), o, 0);
    end
    #HALF;
    cs = 1'b1;
    #(4 * HALF);
    wel_m = 1'b0;
    txb.delete();
    txb = '{8'h03, 8'h00, 8'h00, 8'h40}; do_txn(40, "rstrd");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: for (int j = 0; j < 4; j++) load(16'hFF00 + 16'($urandom_range(0, 511)), 8'($urandom));
        1: begin
          st  = 16'hFF00 + 16'($urandom_range(0, 500));
          len = $urandom_range(1, 6);
          txb = '{8'h03, 8'($urandom), st[15:8], st[7:0]};
          do_txn(32 + 8 * len, "r_read");
        end
        2: begin txb = '{8'h9F}; do_txn(8 + 8 * $urandom_range(1, 5), "r_rdid"); end
        3: begin txb = '{8'h05}; do_txn(8 + 8 * $urandom_range(1, 3), "r_rdsr"); end
        4: begin
          txb = '{($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04};
          do_txn(($urandom_range(0, 1) != 0) ? 8 : $urandom_range(1, 16), "r_wel");
        end
        5: begin
          do op = 8'($urandom);
          while (op == 8'h03 || op == 8'h9F || op == 8'h05 || op == 8'h06 || op == 8'h04 || op == 8'h02);
          txb = '{op};
          do_txn(8 + 8 * $urandom_range(0, 3), "r_unk");
        end
        default: begin
          st  = 16'hFF00 + 16'($urandom_range(0, 500));
          txb = '{8'h03, 8'h00, st[15:8], st[7:0]};
          do_txn($urandom_range(1, 31), "r_abort");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
